instr_mem_loader: RTL

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: collects a big-endian byte stream into 32-bit
// words and issues one write per word to consecutive word addresses.
module instr_mem_loader #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   word_count,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [31:0]   wdata,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned CW = AW + 1;
  localparam logic [AW:0] DEPTH_W = CW'(DEPTH);
  localparam logic [AW:0] ONE_W   = CW'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    DONE    = 3'd3,
    ERR     = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   word_q, word_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          byte_ready_q, byte_ready_d;
  logic          we_q, we_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  // Next-state, datapath update and next-cycle output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    idx_d        = idx_q;
    word_d       = word_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count == '0) begin
            state_d = DONE;
          end else if (word_count > DEPTH_W) begin
            state_d = ERR;
          end else begin
            cnt_d   = word_count;
            ptr_d   = '0;
            idx_d   = 2'd0;
            word_d  = '0;
            state_d = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (byte_valid) begin
          // Shifting in from the right leaves byte 0 in [31:24] after four accepts.
          word_d = {word_q[23:0], byte_in};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            waddr_d = ptr_q;
            wdata_d = {word_q[23:0], byte_in};
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        // Pointer is only advanced when another word follows, so it never wraps.
        if (({1'b0, ptr_q} + ONE_W) == cnt_q) begin
          state_d = DONE;
        end else begin
          ptr_d   = ptr_q + AW'(1);
          idx_d   = 2'd0;
          state_d = COLLECT;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    byte_ready_d = (state_d == COLLECT);
    we_d         = (state_d == WRITE);
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
    err_d        = (state_d == ERR);
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ptr_q        <= '0;
      idx_q        <= 2'd0;
      word_q       <= '0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      byte_ready_q <= 1'b0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      byte_ready_q <= byte_ready_d;
      we_q         <= we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign we         = we_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
